// File: rtl/wash_pkg.sv
// Shared types and constants for the wash payment front-end: FSM states,
// coin codes, the coin value lookup and the default prices.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        START,
        RUNNING,
        REFUND
    } wash_state_t;

    localparam logic [1:0] COIN_INVALID = 2'b00;
    localparam logic [1:0] COIN_1U      = 2'b01;
    localparam logic [1:0] COIN_2U      = 2'b10;
    localparam logic [1:0] COIN_5U      = 2'b11;

    localparam int COIN_VALUE_W = 3;

    localparam int DEFAULT_PRICE_SINGLE   = 8;
    localparam int DEFAULT_PRICE_DOUBLE   = 12;
    localparam int DEFAULT_CREDIT_W       = 5;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

    function automatic logic [COIN_VALUE_W-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VALUE_W-1:0] value;
        case (code)
            COIN_1U: value = 3'd1;
            COIN_2U: value = 3'd2;
            COIN_5U: value = 3'd5;
            default: value = 3'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/wash_coin_frontend_coin_decode.sv
// Combinational coin decoder: maps the 2-bit coin code to its credit value
// and flags the unassigned code.
module coin_decode
    import wash_pkg::*;
(
    input  logic [1:0]              code,
    output logic [COIN_VALUE_W-1:0] value,
    output logic                    invalid
);

    always_comb begin
        value   = coin_value(code);
        invalid = (code == COIN_INVALID);
    end

endmodule

// File: rtl/wash_coin_frontend.sv
// Payment front-end for the washing machine controller: collects coin credit,
// issues one coin_in start pulse plus change, then waits for wash_done.
// Optional idle-collect auto-refund is built when COLLECT_TIMEOUT_EN is defined.
module wash_coin_frontend
    import wash_pkg::*;
#(
    parameter int PRICE_SINGLE   = DEFAULT_PRICE_SINGLE,
    parameter int PRICE_DOUBLE   = DEFAULT_PRICE_DOUBLE,
    parameter int CREDIT_W       = DEFAULT_CREDIT_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                double_wash_req,
    input  logic                cancel,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                busy
);

    logic [COIN_VALUE_W-1:0] coin_val;
    logic                    coin_bad;

    coin_decode u_coin_decode (
        .code    (coin_code),
        .value   (coin_val),
        .invalid (coin_bad)
    );

    wash_state_t         state_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic                wash_done_reg;
    logic                coin_in_reg;
    logic                double_wash_reg;
    logic                coin_reject_reg;
    logic                change_valid_reg;
    logic [CREDIT_W-1:0] change_amount_reg;
    logic                busy_reg;

    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   credit_sum;
    logic                start_cond;
    logic                refund_cond;
    logic                coin_accept;
    logic                wash_done_rise;
    logic                timeout_hit;

    // A coin arriving while the purchase is being started or refunded is
    // returned rather than silently absorbed into a credit that is about to clear.
    always_comb begin
        price          = double_wash_req ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);
        credit_sum     = {1'b0, credit_reg} + (CREDIT_W + 1)'(coin_val);
        start_cond     = (state_reg == COLLECT) && (credit_reg >= price);
        refund_cond    = (state_reg == COLLECT) && !start_cond && (cancel || timeout_hit);
        coin_accept    = coin_valid && !coin_bad && !credit_sum[CREDIT_W] &&
                         ((state_reg == IDLE) ||
                          ((state_reg == COLLECT) && !start_cond && !refund_cond));
        wash_done_rise = wash_done && !wash_done_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            credit_reg        <= '0;
            wash_done_reg     <= 1'b0;
            coin_in_reg       <= 1'b0;
            double_wash_reg   <= 1'b0;
            coin_reject_reg   <= 1'b0;
            change_valid_reg  <= 1'b0;
            change_amount_reg <= '0;
            busy_reg          <= 1'b0;
        end else begin
            wash_done_reg     <= wash_done;
            coin_in_reg       <= 1'b0;
            change_valid_reg  <= 1'b0;
            change_amount_reg <= '0;
            coin_reject_reg   <= coin_valid && !coin_accept;

            case (state_reg)
                IDLE: begin
                    if (coin_accept) begin
                        credit_reg <= credit_sum[CREDIT_W-1:0];
                        state_reg  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (start_cond) begin
                        state_reg       <= START;
                        coin_in_reg     <= 1'b1;
                        double_wash_reg <= double_wash_req;
                        busy_reg        <= 1'b1;
                        credit_reg      <= '0;
                        if (credit_reg > price) begin
                            change_valid_reg  <= 1'b1;
                            change_amount_reg <= credit_reg - price;
                        end
                    end else if (refund_cond) begin
                        state_reg         <= REFUND;
                        credit_reg        <= '0;
                        change_valid_reg  <= (credit_reg != '0);
                        change_amount_reg <= credit_reg;
                    end else if (coin_accept) begin
                        credit_reg <= credit_sum[CREDIT_W-1:0];
                    end
                end
                START: begin
                    state_reg <= RUNNING;
                end
                RUNNING: begin
                    if (wash_done_rise) begin
                        state_reg       <= IDLE;
                        busy_reg        <= 1'b0;
                        double_wash_reg <= 1'b0;
                    end
                end
                REFUND: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef COLLECT_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    generate
        if (TIMEOUT_EN && (TIMEOUT_CYCLES > 0)) begin : g_timeout
            localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [TO_W-1:0] idle_cnt_reg;

            // Counts cycles spent in COLLECT since the last accepted coin.
            always_ff @(posedge clk) begin
                if (!rst_n || coin_accept || (state_reg != COLLECT)) begin
                    idle_cnt_reg <= '0;
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
                end
            end

            assign timeout_hit = (state_reg == COLLECT) &&
                                 (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign coin_in       = coin_in_reg;
    assign double_wash   = double_wash_reg;
    assign coin_reject   = coin_reject_reg;
    assign change_valid  = change_valid_reg;
    assign change_amount = change_amount_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_wash_coin_frontend.sv
// Scoreboard bench for wash_coin_frontend: expected output events are queued
// as stimulus is driven and matched as the DUT emits them.
`timescale 1ns/1ps
module tb_wash_coin_frontend;
    import wash_pkg::*;

    localparam int TB_TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       double_wash_req;
    logic       cancel;
    logic       wash_done;
    logic       coin_in;
    logic       double_wash;
    logic       coin_reject;
    logic       change_valid;
    logic [4:0] change_amount;
    logic       busy;

    // second instance with a price above the credit ceiling, for overflow checks
    logic       w_coin_valid;
    logic [1:0] w_coin_code;
    logic       w_double_wash_req;
    logic       w_cancel;
    logic       w_wash_done;
    logic       w_coin_in;
    logic       w_double_wash;
    logic       w_coin_reject;
    logic       w_change_valid;
    logic [4:0] w_change_amount;
    logic       w_busy;

    always #5 clk = ~clk;

    wash_coin_frontend #(
        .PRICE_SINGLE   (8),
        .PRICE_DOUBLE   (12),
        .CREDIT_W       (5),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .coin_valid      (coin_valid),
        .coin_code       (coin_code),
        .double_wash_req (double_wash_req),
        .cancel          (cancel),
        .wash_done       (wash_done),
        .coin_in         (coin_in),
        .double_wash     (double_wash),
        .coin_reject     (coin_reject),
        .change_valid    (change_valid),
        .change_amount   (change_amount),
        .busy            (busy)
    );

    wash_coin_frontend #(
        .PRICE_SINGLE   (31),
        .PRICE_DOUBLE   (31),
        .CREDIT_W       (5),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut_wide (
        .clk             (clk),
        .rst_n           (rst_n),
        .coin_valid      (w_coin_valid),
        .coin_code       (w_coin_code),
        .double_wash_req (w_double_wash_req),
        .cancel          (w_cancel),
        .wash_done       (w_wash_done),
        .coin_in         (w_coin_in),
        .double_wash     (w_double_wash),
        .coin_reject     (w_coin_reject),
        .change_valid    (w_change_valid),
        .change_amount   (w_change_amount),
        .busy            (w_busy)
    );

    typedef struct packed {
        logic       ci;
        logic       dw;
        logic       cv;
        logic [4:0] amt;
        logic       rej;
    } evt_t;

    evt_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ci, input logic dw, input logic cv,
                        input logic [4:0] amt, input logic rej);
        evt_t e;
        e.ci  = ci;
        e.dw  = dw;
        e.cv  = cv;
        e.amt = amt;
        e.rej = rej;
        exp_q.push_back(e);
    endtask

    task automatic drop_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
        coin_code  = COIN_INVALID;
    endtask

    task automatic w_drop_coin(input logic [1:0] code);
        w_coin_valid = 1'b1;
        w_coin_code  = code;
        tick();
        w_coin_valid = 1'b0;
        w_coin_code  = COIN_INVALID;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_done();
        wash_done = 1'b1;
        tick();
        wash_done = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_coin_in"}, coin_in, 0);
        check_eq({tag, "_double_wash"}, double_wash, 0);
        check_eq({tag, "_coin_reject"}, coin_reject, 0);
        check_eq({tag, "_change_valid"}, change_valid, 0);
        check_eq({tag, "_change_amount"}, change_amount, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // Every cycle with an output event consumes one scoreboard entry.
    always @(negedge clk) begin : monitor
        evt_t e;
        if (coin_in || change_valid || coin_reject) begin
            $display("evt t=%0t coin_in=%0b double_wash=%0b change_valid=%0b change_amount=%0d coin_reject=%0b",
                     $time, coin_in, double_wash, change_valid, change_amount, coin_reject);
            check_eq("sb_expected_event", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("sb_coin_in", coin_in, e.ci);
                check_eq("sb_double_wash", double_wash, e.dw);
                check_eq("sb_change_valid", change_valid, e.cv);
                check_eq("sb_change_amount", change_amount, e.amt);
                check_eq("sb_coin_reject", coin_reject, e.rej);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        coin_valid = 1'b0; coin_code = COIN_INVALID; double_wash_req = 1'b0;
        cancel = 1'b0; wash_done = 1'b0;
        w_coin_valid = 1'b0; w_coin_code = COIN_INVALID; w_double_wash_req = 1'b0;
        w_cancel = 1'b0; w_wash_done = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // single wash, 5+5 -> change 2
        push(1, 0, 1, 5'd2, 0);
        drop_coin(COIN_5U);
        drop_coin(COIN_5U);
        tick();
        check_eq("t1_coin_in", coin_in, 1);
        check_eq("t1_busy_start", busy, 1);
        drain("t1_drain", 5);
        tick();
        check_eq("t1_coin_in_once", coin_in, 0);
        check_eq("t1_busy_run", busy, 1);
        pulse_done();
        check_eq("t1_busy_done", busy, 0);

        // double wash, 5+5+2 -> exact price, mode held through the wash
        double_wash_req = 1'b1;
        push(1, 1, 0, 5'd0, 0);
        drop_coin(COIN_5U);
        drop_coin(COIN_5U);
        drop_coin(COIN_2U);
        tick();
        check_eq("t2_dw_start", double_wash, 1);
        double_wash_req = 1'b0;
        repeat (3) tick();
        check_eq("t2_dw_hold", double_wash, 1);
        check_eq("t2_busy", busy, 1);
        drain("t2_drain", 5);
        pulse_done();
        check_eq("t2_dw_clear", double_wash, 0);
        check_eq("t2_busy_done", busy, 0);

        // cancel refund, then cancel racing a coin
        push(0, 0, 1, 5'd3, 0);
        drop_coin(COIN_2U);
        drop_coin(COIN_1U);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_eq("t3_busy", busy, 0);
        drain("t3_drain", 5);
        tick();
        push(0, 0, 1, 5'd3, 1);
        drop_coin(COIN_2U);
        drop_coin(COIN_1U);
        cancel = 1'b1;
        coin_valid = 1'b1;
        coin_code = COIN_5U;
        tick();
        cancel = 1'b0;
        coin_valid = 1'b0;
        coin_code = COIN_INVALID;
        drain("t3_race_drain", 5);
        check_eq("t3_race_busy", busy, 0);
        tick();

        // invalid code, coin while running, credit untouched afterwards
        push(0, 0, 0, 5'd0, 1);
        drop_coin(COIN_INVALID);
        drain("t4_invalid_drain", 5);
        push(1, 0, 1, 5'd2, 0);
        drop_coin(COIN_5U);
        drop_coin(COIN_5U);
        tick();
        tick();
        push(0, 0, 0, 5'd0, 1);
        drop_coin(COIN_5U);
        drain("t4_running_drain", 5);
        pulse_done();
        push(0, 0, 1, 5'd7, 0);
        drop_coin(COIN_5U);
        drop_coin(COIN_2U);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        drain("t4_credit_drain", 5);
        tick();

        // credit ceiling on the high-price instance: 30 accepted, 35 refused
        for (int i = 0; i < 6; i++) begin
            w_drop_coin(COIN_5U);
            check_eq("ovf_accept", w_coin_reject, 0);
            $display("wide coin %0d accepted", i + 1);
        end
        w_drop_coin(COIN_5U);
        check_eq("ovf_reject", w_coin_reject, 1);
        w_cancel = 1'b1;
        tick();
        w_cancel = 1'b0;
        check_eq("ovf_refund_valid", w_change_valid, 1);
        check_eq("ovf_refund_amount", w_change_amount, 30);
        check_eq("ovf_coin_in", w_coin_in, 0);
        $display("wide refund amount %0d", w_change_amount);

        // reset mid-wash, then wash_done held high across the next purchase
        push(1, 0, 1, 5'd2, 0);
        drop_coin(COIN_5U);
        drop_coin(COIN_5U);
        tick();
        tick();
        check_eq("t5_busy_run", busy, 1);
        drain("t5_pre_drain", 5);
        rst_n = 1'b0;
        wash_done = 1'b1;
        tick();
        check_all_zero("t5_reset");
        tick();
        rst_n = 1'b1;
        tick();
        push(1, 0, 1, 5'd2, 0);
        drop_coin(COIN_5U);
        drop_coin(COIN_5U);
        tick();
        repeat (6) tick();
        check_eq("t5_no_spurious_exit", busy, 1);
        drain("t5_drain", 5);
        wash_done = 1'b0;
        tick();
        pulse_done();
        check_eq("t5_busy_done", busy, 0);

`ifdef COLLECT_TIMEOUT_EN
        push(0, 0, 1, 5'd1, 0);
        drop_coin(COIN_1U);
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            tick();
            waited++;
        end
        check_eq("t6_timeout_refund", exp_q.size(), 0);
        check_eq("t6_timeout_window", (waited >= TB_TIMEOUT - 1) && (waited <= TB_TIMEOUT + 2), 1);
`else
        waited = 0;
        drop_coin(COIN_1U);
        repeat (100) begin
            tick();
            waited++;
        end
        check_eq("t6_still_collecting", busy, 0);
        check_eq("t6_no_refund", exp_q.size(), 0);
        push(0, 0, 1, 5'd1, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        drain("t6_cancel_drain", 5);
`endif
        $display("timeout phase waited %0d cycles", waited);

        drain("final_drain", 10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
